// File: rtl/pipeline_stall_controller.sv
// Stall and flush sequencer for the 5-stage MIPS pipeline. It merges load-use,
// data-memory wait and taken-branch events into the stage enables.
module pipeline_stall_controller #(
   parameter int TIMEOUT = 15,
   parameter int WAIT_W  = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             EXMEM_MemRead,
   input  logic             EXMEM_MemWrite,
   input  logic             dmem_ready,
   input  logic             BranchTaken,
   output logic             PCwrite,
   output logic             IFIDwrite,
   output logic             IDEXwrite,
   output logic             EXMEMwrite,
   output logic             HazardSel,
   output logic             IFIDflush,
   output logic             MEMWBbubble,
   output logic             dmem_req,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                timeout_q, timeout_d;

   logic                memacc;
   logic                memstall;
   logic                loaduse;
   logic                stalled;

   assign memacc  = EXMEM_MemRead | EXMEM_MemWrite;
   // Register 0 is hardwired to zero, so a load into it can never feed a consumer.
   assign loaduse = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

   always_comb begin
      memstall    = 1'b0;
      dmem_req    = 1'b0;
      PCwrite     = 1'b1;
      IFIDwrite   = 1'b1;
      IDEXwrite   = 1'b1;
      EXMEMwrite  = 1'b1;
      HazardSel   = 1'b0;
      IFIDflush   = 1'b0;
      MEMWBbubble = 1'b0;

      case (state_q)
         RUN: begin
            memstall = memacc & ~dmem_ready;
            dmem_req = memacc;
         end
         MEM_WAIT: begin
            memstall = ~dmem_ready;
            dmem_req = memacc;
         end
         default: begin
            memstall = 1'b0;
            dmem_req = 1'b0;
         end
      endcase

      // Priority: error hold, then memory stall, then load-use bubble, then branch flush.
      if (state_q == ERROR || memstall) begin
         PCwrite     = 1'b0;
         IFIDwrite   = 1'b0;
         IDEXwrite   = 1'b0;
         EXMEMwrite  = 1'b0;
         MEMWBbubble = 1'b1;
      end else if (loaduse) begin
         PCwrite   = 1'b0;
         IFIDwrite = 1'b0;
         HazardSel = 1'b1;
      end else if (BranchTaken) begin
         IFIDflush = 1'b1;
      end

      if (!rst) begin
         PCwrite     = 1'b0;
         IFIDwrite   = 1'b0;
         IDEXwrite   = 1'b0;
         EXMEMwrite  = 1'b0;
         HazardSel   = 1'b0;
         IFIDflush   = 1'b0;
         MEMWBbubble = 1'b0;
         dmem_req    = 1'b0;
      end
   end

   assign stalled = memstall | loaduse | (state_q == ERROR);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         RUN: begin
            if (memacc && !dmem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
               state_d   = ERROR;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = ERROR;
         end
      endcase

      // Saturate rather than wrap so a long stall never reads back as a short one.
      if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a default instance plus a
// narrow-counter instance sharing the same stimulus to exercise saturation.
module tb_pipeline_stall_controller;

   logic        clk;
   logic        rst;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_Rt;
   logic [4:0]  IFID_Rs;
   logic [4:0]  IFID_Rt;
   logic        EXMEM_MemRead;
   logic        EXMEM_MemWrite;
   logic        dmem_ready;
   logic        BranchTaken;

   logic        PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite;
   logic        HazardSel, IFIDflush, MEMWBbubble, dmem_req, mem_timeout;
   logic [15:0] stall_count;

   logic        satPCwrite, satIFIDwrite, satIDEXwrite, satEXMEMwrite;
   logic        satHazardSel, satIFIDflush, satMEMWBbubble, satDmemReq, satMemTimeout;
   logic [3:0]  satStallCount;

   typedef struct {
      int         step;
      logic [8:0] ctl;
      int         cnt;
   } expect_t;

   expect_t expQ[$];
   int      checkCount = 0;
   int      failCount  = 0;
   int      stepNum    = 0;

   pipeline_stall_controller #(.TIMEOUT(15), .WAIT_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
      .dmem_ready(dmem_ready), .BranchTaken(BranchTaken),
      .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .IDEXwrite(IDEXwrite),
      .EXMEMwrite(EXMEMwrite), .HazardSel(HazardSel), .IFIDflush(IFIDflush),
      .MEMWBbubble(MEMWBbubble), .dmem_req(dmem_req),
      .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   pipeline_stall_controller #(.TIMEOUT(15), .WAIT_W(4), .CNT_W(4)) dutSat (
      .clk(clk), .rst(rst),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
      .dmem_ready(dmem_ready), .BranchTaken(BranchTaken),
      .PCwrite(satPCwrite), .IFIDwrite(satIFIDwrite), .IDEXwrite(satIDEXwrite),
      .EXMEMwrite(satEXMEMwrite), .HazardSel(satHazardSel), .IFIDflush(satIFIDflush),
      .MEMWBbubble(satMEMWBbubble), .dmem_req(satDmemReq),
      .mem_timeout(satMemTimeout), .stall_count(satStallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control vector order: PC, IFID, IDEX, EXMEM, HazardSel, IFIDflush, MEMWBbubble, dmem_req, mem_timeout.
   localparam logic [8:0] NORMAL   = 9'b1111_0000_0;
   localparam logic [8:0] NORMREQ  = 9'b1111_0001_0;
   localparam logic [8:0] LOADUSE  = 9'b0011_1000_0;
   localparam logic [8:0] LUREQ    = 9'b0011_1001_0;
   localparam logic [8:0] FLUSH    = 9'b1111_0100_0;
   localparam logic [8:0] MEMSTALL = 9'b0000_0011_0;
   localparam logic [8:0] ERRHOLD  = 9'b0000_0010_1;
   localparam logic [8:0] RSTERR   = 9'b0000_0000_1;
   localparam logic [8:0] ALLZERO  = 9'b0000_0000_0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs just after the clock edge and queues what the outputs must be.
   task automatic applyStimulus(input logic rstN, input logic memRd, input logic [4:0] idexRt,
                                input logic [4:0] ifidRs, input logic [4:0] ifidRt,
                                input logic exRd, input logic exWr, input logic ready,
                                input logic br, input logic [8:0] expCtl, input int expCnt);
      expect_t e;
      @(posedge clk);
      #1;
      rst            = rstN;
      IDEX_MemRead   = memRd;
      IDEX_Rt        = idexRt;
      IFID_Rs        = ifidRs;
      IFID_Rt        = ifidRt;
      EXMEM_MemRead  = exRd;
      EXMEM_MemWrite = exWr;
      dmem_ready     = ready;
      BranchTaken    = br;
      stepNum++;
      e.step = stepNum;
      e.ctl  = expCtl;
      e.cnt  = expCnt;
      expQ.push_back(e);
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         expect_t e;
         int satCnt;
         e = expQ.pop_front();
         satCnt = (e.cnt > 15) ? 15 : e.cnt;
         checkOutput($sformatf("ctl@step%0d", e.step),
                     {23'd0, PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite, HazardSel,
                      IFIDflush, MEMWBbubble, dmem_req, mem_timeout}, {23'd0, e.ctl});
         checkOutput($sformatf("cnt@step%0d", e.step), {16'd0, stall_count}, 32'(e.cnt));
         checkOutput($sformatf("satcnt@step%0d", e.step), {28'd0, satStallCount}, 32'(satCnt));
      end
   end

   initial begin
      rst = 1'b0;
      IDEX_MemRead = 1'b0; IDEX_Rt = '0; IFID_Rs = '0; IFID_Rt = '0;
      EXMEM_MemRead = 1'b0; EXMEM_MemWrite = 1'b0; dmem_ready = 1'b0; BranchTaken = 1'b0;
      @(posedge clk);

      // Reset holds every control low even with hazards present.
      applyStimulus(0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 1, ALLZERO, 0);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NORMAL,  0);
      // Load-use on rs, then idle, then register-0 match, then load-use on rt.
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, LOADUSE, 0);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NORMAL,  1);
      applyStimulus(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NORMAL,  1);
      applyStimulus(1, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, LOADUSE, 1);
      // Zero-wait read.
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, NORMREQ, 2);
      // Three-cycle write, released on the ready cycle.
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, MEMSTALL, 2);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, MEMSTALL, 3);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, MEMSTALL, 4);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, NORMREQ,  5);
      // Memory stall masks load-use and branch; load-use then wins; branch flushes last.
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 1, MEMSTALL, 5);
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 1, 1, LUREQ,    6);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, FLUSH,    7);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NORMAL,   7);
      // Sixteen stalled cycles lead into the error state.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, MEMSTALL, 7 + i);
      end
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, ERRHOLD, 23);
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 1, ERRHOLD, 24);
      // One reset cycle clears the error and the counters.
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RSTERR,  25);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NORMAL,  0);
      applyStimulus(1, 1, 5'd4, 5'd0, 5'd4, 0, 0, 0, 0, LOADUSE, 0);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NORMAL,  1);

      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
